// File: rtl/rr_reg_arbiter_if.sv
// rr_reg_arbiter_if
// Bundle between N requesters and the round-robin shared register.
// The requester side (master) drives req/din and observes the grant and the
// register; the arbiter side (slave) does the reverse.
interface rr_reg_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IW = $clog2(N);

    logic [N-1:0]   req;      // per-requester request, held for the whole use
    logic [N*W-1:0] din;      // requester i drives din[i*W +: W]
    logic [N-1:0]   gnt;      // registered one-hot grant, zero when idle
    logic [IW-1:0]  owner;    // index of the granted requester, sticky when idle
    logic [W-1:0]   dout;     // shared register contents
    logic           dvalid;   // dout belongs to a currently granted requester
    logic           timeout;  // one-cycle pulse when a grant is revoked

    modport master (
        output req, din,
        input  gnt, owner, dout, dvalid, timeout
    );

    modport slave (
        input  req, din,
        output gnt, owner, dout, dvalid, timeout
    );
endinterface

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter
// Round-robin arbiter guarding one W-bit shared register among N requesters.
// A two-state FSM (IDLE/BUSY) grants the first requester found searching
// upward from a rotating pointer; while the owner holds req the register
// reloads from its data slice every cycle. Releasing the grant always costs
// one IDLE cycle, and the pointer moves to the owner's successor.
//
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant that has lasted
// TIMEOUT cycles (8-bit counter, one-cycle timeout pulse). Without the macro
// there is no counter and timeout is tied low.
module rr_reg_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    rr_reg_arbiter_if.slave  bus
);

    localparam int            IW  = $clog2(N);
    localparam logic [IW:0]   N_W = (IW + 1)'(N);

    // Elaboration-time parameter range checks.
    if (N < 2 || N > 8) begin : g_bad_n
        $error("rr_reg_arbiter: N must be in 2..8");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_reg_arbiter: TIMEOUT must be in 2..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q,   gnt_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  ptr_q,   ptr_d;
    logic [W-1:0]   dout_q,  dout_d;
    logic           dvalid_q, dvalid_d;

`ifdef ARB_TIMEOUT_EN
    // Counter value seen on the edge where the grant has lasted TIMEOUT cycles:
    // it is cleared on the granting edge and bumped on every following BUSY edge.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0]     cnt_q, cnt_d;
    logic           timeout_q, timeout_d;
`endif

    // Per-requester view of the packed data bus.
    logic [W-1:0]   din_arr [N];

    // Arbitration result for the current cycle.
    logic           found;
    logic [IW-1:0]  win;
    logic [IW-1:0]  cand;

    // (base + step) mod N for base < N and step < N.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                               input logic [IW:0]   step);
        logic [IW+1:0] sum;
        sum = {2'b00, base} + {1'b0, step};
        if (sum >= {1'b0, N_W}) begin
            sum = sum - {1'b0, N_W};
        end
        return sum[IW-1:0];
    endfunction

    // Unpack din into one slice per requester.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            din_arr[i] = bus.din[i*W +: W];
        end
    end

    // First requester with req high, searching from ptr upward modulo N.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < N; k++) begin
            cand = wrap_add(ptr_q, (IW + 1)'(k));
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and next-output logic of the IDLE/BUSY FSM.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = BUSY;
                    gnt_d    = {{(N-1){1'b0}}, 1'b1} << win;
                    owner_d  = win;
                    dout_d   = din_arr[win];
                    dvalid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d    = 8'd0;
`endif
                end
            end

            BUSY: begin
                // Release wins over timeout when both land on the same edge.
                if (!bus.req[owner_q]) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    dvalid_d = 1'b0;
                    ptr_d    = wrap_add(owner_q, (IW + 1)'(1));
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    dvalid_d  = 1'b0;
                    ptr_d     = wrap_add(owner_q, (IW + 1)'(1));
                    timeout_d = 1'b1;
                end
`endif
                else begin
                    // Non-owner requests are simply not looked at here.
                    dout_d = din_arr[owner_q];
`ifdef ARB_TIMEOUT_EN
                    cnt_d  = cnt_q + 8'd1;
`endif
                end
            end

            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                dvalid_d = 1'b0;
            end
        endcase
    end

    // State register; reset drops any grant and restarts arbitration at requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Grant-length counter and timeout pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt    = gnt_q;
    assign bus.owner  = owner_q;
    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter
// Self-checking bench for rr_reg_arbiter (N=4, W=8, TIMEOUT=8): a vector
// table for the basic handshake, hand-written multi-cycle sequences, and a
// randomized run against a cycle-level model built from the arbitration rules.
// Define ARB_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_rr_reg_arbiter;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    rr_reg_arbiter_if #(.N(N), .W(W)) bus ();

    rr_reg_arbiter #(
        .N       (N),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic [7:0]  dout;
        logic        dvalid;
    } vec_t;

    vec_t vt [17];

    // Reference model state: plain integers, rules applied directly.
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_len;
    logic [7:0] m_dout;
    bit         m_to;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] g, input logic [1:0] o,
                                 input logic [7:0] dd, input logic dv, input logic to);
        check($sformatf("%s.gnt", tag),     32'(bus.gnt),     32'(g));
        check($sformatf("%s.owner", tag),   32'(bus.owner),   32'(o));
        check($sformatf("%s.dout", tag),    32'(bus.dout),    32'(dd));
        check($sformatf("%s.dvalid", tag),  32'(bus.dvalid),  32'(dv));
        check($sformatf("%s.timeout", tag), 32'(bus.timeout), 32'(to));
    endtask

    // Drive inputs, let one rising edge pass, return 1 time unit after it.
    task automatic tick(input logic [3:0] r, input logic [31:0] d);
        bus.req = r;
        bus.din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = '0;
        bus.din = '0;
        reset   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_len   = 0;
        m_dout  = '0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [31:0] d);
        m_to = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (r[c]) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_dout  = d[c*W +: W];
                    m_len   = 1;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
        end else if (TO_EN && m_len >= TIMEOUT) begin
            m_busy = 1'b0;
            m_to   = 1'b1;
            m_ptr  = (m_owner + 1) % N;
        end else begin
            m_dout = d[m_owner*W +: W];
            m_len++;
        end
    endtask

    initial begin
        logic [3:0]  r;
        logic [31:0] d;
        logic [3:0]  onehot;

        //             req      din            gnt      own    dout   dv
        vt[0]  = '{4'b0000, 32'h0000_0000, 4'b0000, 2'd0, 8'h00, 1'b0};
        vt[1]  = '{4'b0000, 32'h0000_0000, 4'b0000, 2'd0, 8'h00, 1'b0};
        vt[2]  = '{4'b0000, 32'h0000_0000, 4'b0000, 2'd0, 8'h00, 1'b0};
        vt[3]  = '{4'b0000, 32'h0000_0000, 4'b0000, 2'd0, 8'h00, 1'b0};
        vt[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 2'd0, 8'h00, 1'b0};
        vt[5]  = '{4'b0010, 32'h0000_A500, 4'b0010, 2'd1, 8'hA5, 1'b1};
        vt[6]  = '{4'b0000, 32'h0000_0000, 4'b0000, 2'd1, 8'hA5, 1'b0};
        vt[7]  = '{4'b0001, 32'h0000_0001, 4'b0001, 2'd0, 8'h01, 1'b1};
        vt[8]  = '{4'b0011, 32'h0000_EE02, 4'b0001, 2'd0, 8'h02, 1'b1};
        vt[9]  = '{4'b0001, 32'h0000_0003, 4'b0001, 2'd0, 8'h03, 1'b1};
        vt[10] = '{4'b0000, 32'h0000_0000, 4'b0000, 2'd0, 8'h03, 1'b0};
        vt[11] = '{4'b0011, 32'h0000_4433, 4'b0010, 2'd1, 8'h44, 1'b1};
        vt[12] = '{4'b1001, 32'h7700_0000, 4'b0000, 2'd1, 8'h44, 1'b0};
        vt[13] = '{4'b1001, 32'h7700_0055, 4'b1000, 2'd3, 8'h77, 1'b1};
        vt[14] = '{4'b0000, 32'h0000_0000, 4'b0000, 2'd3, 8'h77, 1'b0};
        vt[15] = '{4'b1001, 32'h8800_0066, 4'b0001, 2'd0, 8'h66, 1'b1};
        vt[16] = '{4'b0000, 32'h0000_0000, 4'b0000, 2'd0, 8'h66, 1'b0};

        // Outputs while reset is held low.
        bus.req = 4'b1111;
        bus.din = 32'hFFFF_FFFF;
        #12;
        check_outputs("in_reset", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);

        // Vector table: idle after reset, single grants, dout tracking, pointer wrap.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            tick(vt[i].req, vt[i].din);
            check_outputs($sformatf("vec%0d", i), vt[i].gnt, vt[i].owner, vt[i].dout, vt[i].dvalid, 1'b0);
        end

        // All four requesting, each drops req two cycles after its grant.
        do_reset();
        d = 32'hD3C2_B1A0;
        for (int g = 0; g < 5; g++) begin
            int o;
            o = g % N;
            onehot = 4'(1 << o);
            tick(4'b1111, d);
            check_outputs($sformatf("rr%0d.grant", g), onehot, 2'(o), d[o*W +: W], 1'b1, 1'b0);
            tick(4'b1111, d);
            check_outputs($sformatf("rr%0d.hold", g), onehot, 2'(o), d[o*W +: W], 1'b1, 1'b0);
            tick(4'b1111 & ~onehot, d);
            check_outputs($sformatf("rr%0d.idle", g), 4'b0000, 2'(o), d[o*W +: W], 1'b0, 1'b0);
        end

        // Reset pulsed mid-grant to requester 2, then restart from requester 0.
        do_reset();
        tick(4'b0100, 32'h00C3_0000);
        check_outputs("rst_mid.grant", 4'b0100, 2'd2, 8'hC3, 1'b1, 1'b0);
        tick(4'b0100, 32'h00C4_0000);
        check_outputs("rst_mid.hold", 4'b0100, 2'd2, 8'hC4, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("rst_mid.async", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
        bus.req = 4'b1100;
        @(posedge clk);
        #1;
        check_outputs("rst_mid.held", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        tick(4'b1100, 32'h6B5A_0000);
        check_outputs("rst_mid.regrant", 4'b0100, 2'd2, 8'h5A, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Requesters 0 and 2 held: requester 0 is cut off after TIMEOUT cycles.
        do_reset();
        d = 32'h0022_0011;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick(4'b0101, d);
            check_outputs($sformatf("to.own0_%0d", i), 4'b0001, 2'd0, 8'h11, 1'b1, 1'b0);
        end
        tick(4'b0101, d);
        check_outputs("to.pulse", 4'b0000, 2'd0, 8'h11, 1'b0, 1'b1);
        tick(4'b0101, d);
        check_outputs("to.next", 4'b0100, 2'd2, 8'h22, 1'b1, 1'b0);
        for (int i = 1; i < TIMEOUT; i++) begin
            tick(4'b0101, d);
            check_outputs($sformatf("to.own2_%0d", i), 4'b0100, 2'd2, 8'h22, 1'b1, 1'b0);
        end
        // Release on the very edge the timeout would fire: no pulse.
        tick(4'b0001, d);
        check_outputs("to.release_wins", 4'b0000, 2'd2, 8'h22, 1'b0, 1'b0);
        tick(4'b0001, d);
        check_outputs("to.after", 4'b0001, 2'd0, 8'h11, 1'b1, 1'b0);
`endif

        // Randomized run against the reference model; requests are sticky.
        do_reset();
        model_reset();
        r = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            d = $urandom();
            tick(r, d);
            model_step(r, d);
            check_outputs($sformatf("rand%0d", cyc),
                          m_busy ? 4'(1 << m_owner) : 4'b0000,
                          2'(m_owner), m_dout, m_busy, m_to);
            check($sformatf("rand%0d.onehot", cyc), 32'($countones(bus.gnt) <= 1), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing the register (2..8).
REQ-002 Parameter W, default 8, width of the shared data register.
REQ-003 Parameter TIMEOUT, default 8, maximum grant length in cycles when ARB_TIMEOUT_EN is defined (2..255).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  N  per-requester request; requester i holds req[i] high for as long as it uses the register.
REQ-007 din  input  N*W  per-requester data; requester i drives din[i*W +: W].
REQ-008 gnt  output  N  registered one-hot grant; all-zero when idle.
REQ-009 owner  output  clog2(N)  index of the granted requester; holds the last owner when idle.
REQ-010 dout  output  W  shared register contents.
REQ-011 dvalid  output  1  high while dout holds data of a currently granted requester.
REQ-012 timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 The block shall implement a two-state FSM: IDLE and BUSY.
REQ-014 In IDLE, when any req bit is high at a rising edge, the block shall select the first requester with req high, searching from ptr upward modulo N.
REQ-015 On that edge it shall set gnt to the winner's one-hot, owner to its index, dout to the winner's din slice, dvalid to 1, and enter BUSY, giving 1-cycle latency from req to gnt.
REQ-016 In BUSY with req[owner] high and no timeout, dout shall reload the owner's din slice every edge; gnt and owner shall stay unchanged.
REQ-017 In BUSY, when req[owner] is sampled low, the block shall clear gnt and dvalid, keep dout, set ptr to (owner+1) mod N, and return to IDLE.
REQ-018 A released grant shall always be followed by at least one IDLE cycle; back-to-back grants shall therefore be separated by exactly one cycle with gnt all-zero.
REQ-019 Requests from non-owners during BUSY shall be ignored; they shall not be latched and shall compete normally in the next IDLE cycle.
REQ-020 With a single requester holding req continuously, absent timeout, it shall keep the grant indefinitely.
REQ-021 ptr shall wrap from N-1 to 0; no requester shall wait more than N grants when all requests stay asserted.
REQ-022 gnt shall never have more than one bit set.

Reset
REQ-023 While reset is low, asynchronously: state IDLE, gnt 0, owner 0, ptr 0, dout 0, dvalid 0, timeout 0, cycle counter 0.
REQ-024 Reset asserted mid-grant shall drop the grant immediately without a pointer update; after release, arbitration restarts from requester 0.
REQ-025 The first arbitration shall occur on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN shall control the grant-timeout feature.
REQ-027 With ARB_TIMEOUT_EN defined, an 8-bit counter shall clear on entry to BUSY and increment on each BUSY edge.
REQ-028 With ARB_TIMEOUT_EN defined, if req[owner] is still high on the edge where the grant has lasted TIMEOUT cycles, the block shall clear gnt and dvalid, pulse timeout for one cycle, advance ptr to (owner+1) mod N, and enter IDLE.
REQ-029 Release and timeout on the same edge shall count as a normal release; timeout shall not pulse.
REQ-030 Without ARB_TIMEOUT_EN, no counter shall exist, timeout shall be tied to 0, and grants shall end only on release or reset.

Verification
REQ-031 Reset low, then high; req=4'b0000 -> gnt=0, dvalid=0, dout=0 for 5 cycles.
REQ-032 req=4'b0010, din[1]=8'hA5 -> after one edge gnt=4'b0010, owner=1, dout=8'hA5, dvalid=1; req low -> gnt=0 on the next edge.
REQ-033 req=4'b1111 held, each requester drops req 2 cycles after its grant -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-034 req=4'b0001 with din[0] stepping 1,2,3 per cycle -> dout follows 1,2,3 one cycle later while gnt=4'b0001.
REQ-035 ARB_TIMEOUT_EN, TIMEOUT=8, req=4'b0101 held -> gnt[0] for 8 cycles, timeout pulse, 1 idle cycle, then gnt=4'b0100.
REQ-036 Reset pulsed low during owner=2 grant -> gnt=0 and dout=0 immediately; after release with req=4'b1100, the next grant is requester 2 (ptr=0).
